// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the 16-bit 5-stage pipeline control.
package pipe_pkg;
  localparam int REG_W = 4;
  localparam logic [REG_W-1:0] ZERO_REG = '0;
  typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED, ERROR} state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit saturating up-counter with async active-low clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + W'(1);
endmodule

// File: rtl/hazard_control.sv
// hazard_control: stall/flush controller covering load-use, multi-cycle memory
// accesses and ID-resolved taken branches, with halt/timeout status and counters.
module hazard_control
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] ID_rs,
  input  logic [REG_W-1:0] ID_rt,
  input  logic             ID_rsValid,
  input  logic             ID_rtValid,
  input  logic [REG_W-1:0] EX_destReg,
  input  logic             EX_MemRead,
  input  logic             EX_RegWrite,
  input  logic             ID_BranchTaken,
  input  logic             MEM_MemAccess,
  input  logic             dmem_ready,
  input  logic             WB_Halt,
  output logic             PC_stall,
  output logic             IFID_stall,
  output logic             IFID_flush,
  output logic             IDEX_stall,
  output logic             IDEX_bubble,
  output logic             EXMEM_stall,
  output logic             MEMWB_bubble,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  state_t state, state_nx;
  logic [WW-1:0] wait_cnt, wait_nx, wait_inc;
  logic load_use, mem_hold, in_run, in_wait, active, frz, norm, bubble, flush, timeout;
  assign load_use = EX_MemRead & EX_RegWrite & (EX_destReg != ZERO_REG) &
                    ((ID_rsValid & (ID_rs == EX_destReg)) | (ID_rtValid & (ID_rt == EX_destReg)));
  assign mem_hold = MEM_MemAccess & ~dmem_ready;
  assign in_run   = state == RUN;
  assign in_wait  = state == MEM_WAIT;
  assign active   = in_run | in_wait;
  // MEM_WAIT keeps the pipe frozen until the outstanding access reports ready
  assign frz    = (state == ERROR) | (in_run & mem_hold) | (in_wait & ~dmem_ready);
  assign norm   = (in_run & ~mem_hold) | (in_wait & dmem_ready);
  assign bubble = norm & load_use;
  assign flush  = (norm & ~load_use & ID_BranchTaken) | (state == HALTED);
  assign PC_stall     = rst_n & (frz | bubble | (state == HALTED));
  assign IFID_stall   = rst_n & (frz | bubble);
  assign IFID_flush   = rst_n & flush;
  assign IDEX_stall   = rst_n & frz;
  assign IDEX_bubble  = rst_n & bubble;
  assign EXMEM_stall  = rst_n & frz;
  assign MEMWB_bubble = rst_n & frz;
  assign halted  = state == HALTED;
  assign mem_err = state == ERROR;
  assign wait_inc = wait_cnt + WW'(1);
  assign timeout  = in_wait & ~dmem_ready & (wait_inc >= WW'(MEM_TIMEOUT));
  always_comb begin
    state_nx = timeout ? ERROR :
               (active & WB_Halt) ? HALTED :
               (in_run & mem_hold) ? MEM_WAIT :
               (in_wait & dmem_ready) ? RUN : state;
    wait_nx  = (in_run & mem_hold) ? WW'(1) :
               (in_wait & ~dmem_ready) ? wait_inc : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
    end
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .inc(active & PC_stall), .cnt(stall_cnt)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .inc(active & IFID_flush), .cnt(flush_cnt)
  );
endmodule

// File: tb/tb_hazard_control.sv
// tb_hazard_control: vector table plus hand sequences for hazard_control
// (built with MEM_TIMEOUT=4, CNT_W=2 so timeout and saturation are reachable).
module tb_hazard_control;
  logic clk = 0, rst_n = 0;
  logic [3:0] ID_rs, ID_rt, EX_destReg;
  logic ID_rsValid, ID_rtValid, EX_MemRead, EX_RegWrite, ID_BranchTaken;
  logic MEM_MemAccess, dmem_ready, WB_Halt;
  logic PC_stall, IFID_stall, IFID_flush, IDEX_stall, IDEX_bubble, EXMEM_stall, MEMWB_bubble;
  logic halted, mem_err;
  logic [1:0] stall_cnt, flush_cnt;
  logic [6:0] ctl;
  always #5 clk = ~clk;
  hazard_control #(.MEM_TIMEOUT(4), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_rsValid(ID_rsValid), .ID_rtValid(ID_rtValid), .EX_destReg(EX_destReg),
    .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .ID_BranchTaken(ID_BranchTaken),
    .MEM_MemAccess(MEM_MemAccess), .dmem_ready(dmem_ready), .WB_Halt(WB_Halt),
    .PC_stall(PC_stall), .IFID_stall(IFID_stall), .IFID_flush(IFID_flush),
    .IDEX_stall(IDEX_stall), .IDEX_bubble(IDEX_bubble), .EXMEM_stall(EXMEM_stall),
    .MEMWB_bubble(MEMWB_bubble), .halted(halted), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  assign ctl = {PC_stall, IFID_stall, IFID_flush, IDEX_stall, IDEX_bubble, EXMEM_stall, MEMWB_bubble};
  typedef struct packed {
    logic [3:0] rs, rt;
    logic rsv, rtv;
    logic [3:0] dest;
    logic mr, rw, br, ma, rdy, halt;
  } in_t;
  typedef struct packed {
    in_t i;
    logic [6:0] ctl;
    logic [1:0] sc, fc;
  } vec_t;
  localparam logic [6:0] C0  = 7'b0000000;
  localparam logic [6:0] CLU = 7'b1100100;
  localparam logic [6:0] CBR = 7'b0010000;
  localparam logic [6:0] CFZ = 7'b1101011;
  localparam logic [6:0] CH  = 7'b1010000;
  vec_t vecs[12];
  logic [6:0] sb[$];
  int checks = 0, failures = 0;
  in_t idle, lu, lu_br, br, hold, rdy, halt;
  function automatic in_t mk(input logic [3:0] rs, rt, input logic rsv, rtv,
                             input logic [3:0] dest, input logic mr, rw, br_, ma, rd, hl);
    return '{rs, rt, rsv, rtv, dest, mr, rw, br_, ma, rd, hl};
  endfunction
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic put(input in_t v);
    {ID_rs, ID_rt, ID_rsValid, ID_rtValid, EX_destReg, EX_MemRead, EX_RegWrite,
     ID_BranchTaken, MEM_MemAccess, dmem_ready, WB_Halt} = v;
  endtask
  task automatic drive(input in_t v, input logic [6:0] e, input string name);
    put(v);
    sb.push_back(e);
    #1;
    chk(name, 16'(ctl), 16'(sb.pop_front()));
  endtask
  task automatic do_reset;
    put(idle);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask
  initial begin
    idle  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lu    = mk(3, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0);
    lu_br = mk(3, 0, 1, 0, 3, 1, 1, 1, 0, 0, 0);
    br    = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    hold  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    rdy   = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    halt  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[0]  = '{idle, C0, 2'd0, 2'd0};
    vecs[1]  = '{lu, CLU, 2'd1, 2'd0};
    vecs[2]  = '{mk(0, 5, 0, 1, 5, 1, 1, 0, 0, 0, 0), CLU, 2'd1, 2'd0};
    vecs[3]  = '{mk(0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0), C0, 2'd0, 2'd0};
    vecs[4]  = '{mk(3, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0), C0, 2'd0, 2'd0};
    vecs[5]  = '{mk(3, 0, 1, 0, 3, 0, 1, 0, 0, 0, 0), C0, 2'd0, 2'd0};
    vecs[6]  = '{mk(3, 0, 1, 0, 3, 1, 0, 0, 0, 0, 0), C0, 2'd0, 2'd0};
    vecs[7]  = '{br, CBR, 2'd0, 2'd1};
    vecs[8]  = '{lu_br, CLU, 2'd1, 2'd0};
    vecs[9]  = '{hold, CFZ, 2'd1, 2'd0};
    vecs[10] = '{mk(3, 0, 1, 0, 3, 1, 1, 1, 1, 0, 0), CFZ, 2'd1, 2'd0};
    vecs[11] = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0), CBR, 2'd0, 2'd1};
    // controls must read 0 while reset is held, even with hazards present
    put(mk(3, 0, 1, 0, 3, 1, 1, 1, 1, 0, 0));
    #2;
    chk("reset ctl", 16'(ctl), 16'(C0));
    chk("reset cnt", 16'({stall_cnt, flush_cnt, halted, mem_err}), 16'd0);
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      do_reset();
      drive(vecs[i].i, vecs[i].ctl, $sformatf("vec%0d ctl", i));
      @(negedge clk);
      chk($sformatf("vec%0d stall_cnt", i), 16'(stall_cnt), 16'(vecs[i].sc));
      chk($sformatf("vec%0d flush_cnt", i), 16'(flush_cnt), 16'(vecs[i].fc));
    end
    // load-use then NOP: exactly one bubble
    do_reset();
    drive(lu, CLU, "lu bubble");
    @(negedge clk);
    drive(idle, C0, "lu after nop");
    chk("lu stall_cnt", 16'(stall_cnt), 16'd1);
    // memory wait of 3 cycles then ready
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(hold, CFZ, $sformatf("memwait freeze%0d", i));
      @(negedge clk);
    end
    drive(rdy, C0, "memwait ready");
    @(negedge clk);
    drive(idle, C0, "memwait back to run");
    chk("memwait stall_cnt", 16'(stall_cnt), 16'd3);
    // branch during load-use is deferred a cycle
    do_reset();
    drive(lu_br, CLU, "br+lu");
    @(negedge clk);
    drive(br, CBR, "br retry");
    @(negedge clk);
    chk("br flush_cnt", 16'(flush_cnt), 16'd1);
    chk("br stall_cnt", 16'(stall_cnt), 16'd1);
    // timeout into ERROR, then async reset mid-freeze
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(hold, CFZ, $sformatf("timeout freeze%0d", i));
      @(negedge clk);
      if (i == 2) chk("mem_err early", 16'(mem_err), 16'd0);
    end
    chk("mem_err set", 16'(mem_err), 16'd1);
    drive(rdy, CFZ, "error freeze ready");
    @(negedge clk);
    drive(idle, CFZ, "error freeze idle");
    chk("timeout stall sat", 16'(stall_cnt), 16'd3);
    rst_n = 0;
    #1;
    chk("midreset ctl", 16'(ctl), 16'(C0));
    chk("midreset status", 16'({stall_cnt, flush_cnt, halted, mem_err}), 16'd0);
    @(negedge clk);
    rst_n = 1;
    drive(idle, C0, "after reset run");
    // halt is sticky and not counted
    do_reset();
    drive(halt, C0, "halt cycle");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(lu_br, CH, $sformatf("halted ctl%0d", i));
      chk($sformatf("halted%0d", i), 16'(halted), 16'd1);
    end
    @(negedge clk);
    chk("halted counters", 16'({stall_cnt, flush_cnt}), 16'd0);
    // halt and timeout in the same cycle: ERROR wins
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(hold, CFZ, $sformatf("halt+to freeze%0d", i));
      @(negedge clk);
    end
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1), CFZ, "halt+to last");
    @(negedge clk);
    chk("halt+to status", 16'({halted, mem_err}), 16'b01);
    // saturation of stall_cnt
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(lu, CLU, $sformatf("sat lu%0d", i));
      @(negedge clk);
      if (i == 1) chk("sat mid", 16'(stall_cnt), 16'd2);
    end
    chk("sat stall_cnt", 16'(stall_cnt), 16'd3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_control.md
Name: hazard_control

Overview:
- Stall/flush controller for the 16-bit 5-stage pipeline. It sits upstream of the EX-stage operand forwarding logic.
- Detects hazards that forwarding cannot cover:
  - load-use, which needs a one-cycle bubble;
  - multi-cycle data-memory accesses, which freeze the pipe;
  - taken branches resolved in ID, which flush IF/ID.
- Also tracks halt and memory-timeout status and keeps saturating stall/flush performance counters.

Parameters:
- MEM_TIMEOUT, 64: max cycles in MEM_WAIT before error.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- ID_rs  in  4  source reg 1 of the instruction in ID.
- ID_rt  in  4  source reg 2 of the instruction in ID.
- ID_rsValid  in  1  ID instruction reads rs.
- ID_rtValid  in  1  ID instruction reads rt.
- EX_destReg  in  4  destination reg of the instruction in EX.
- EX_MemRead  in  1  EX instruction is a load.
- EX_RegWrite  in  1  EX instruction writes a reg.
- ID_BranchTaken  in  1  branch in ID resolved taken this cycle.
- MEM_MemAccess  in  1  MEM instruction is a load or store.
- dmem_ready  in  1  data memory completes the access this cycle.
- WB_Halt  in  1  HLT instruction is in WB.
- PC_stall  out  1  hold PC.
- IFID_stall  out  1  hold the IF/ID register.
- IFID_flush  out  1  load a NOP into IF/ID.
- IDEX_stall  out  1  hold the ID/EX register.
- IDEX_bubble  out  1  load a NOP into ID/EX.
- EXMEM_stall  out  1  hold the EX/MEM register.
- MEMWB_bubble  out  1  load a NOP into MEM/WB.
- halted  out  1  sticky halt status.
- mem_err  out  1  sticky memory-timeout error.
- stall_cnt  out  CNT_W  saturating count of stall cycles.
- flush_cnt  out  CNT_W  saturating count of flushes.

Behaviour:
- Reset (async, rst_n=0):
  - state=RUN;
  - halted=0, mem_err=0;
  - stall_cnt=0, flush_cnt=0, wait_cnt=0.
  - All control outputs are 0 during reset.
- Control outputs are combinational from state plus inputs (same-cycle effect). State and counters update on the rising edge of clk.
- Definitions:
  - load_use = EX_MemRead & EX_RegWrite & (EX_destReg!=0) & ((ID_rsValid & ID_rs==EX_destReg) | (ID_rtValid & ID_rt==EX_destReg)).
  - mem_hold = MEM_MemAccess & ~dmem_ready.
  - Register 0 never causes a hazard.
- RUN state, in priority order:
  1. mem_hold:
     - PC_stall, IFID_stall, IDEX_stall, EXMEM_stall = 1; MEMWB_bubble = 1.
     - Next state MEM_WAIT, wait_cnt = 1.
     - IFID_flush is suppressed.
  2. else load_use:
     - PC_stall = 1, IFID_stall = 1, IDEX_bubble = 1.
     - IFID_flush is suppressed, because the branch is re-evaluated next cycle.
     - Exactly one bubble is inserted; state stays RUN.
  3. else ID_BranchTaken: IFID_flush = 1.
- MEM_WAIT state:
  - Same freeze outputs as rule 1 while mem_hold.
  - When dmem_ready=1: outputs are as in RUN for this cycle (load_use/branch are evaluated normally), next state RUN, wait_cnt = 0.
  - Otherwise wait_cnt increments. When wait_cnt reaches MEM_TIMEOUT with no ready: next state ERROR, mem_err = 1.
- ERROR state:
  - PC/IFID/IDEX/EXMEM stall = 1, MEMWB_bubble = 1, every cycle.
  - Exited only by reset.
- Halt:
  - WB_Halt=1 in RUN or MEM_WAIT: next state HALTED, halted = 1.
  - HALTED holds PC_stall = 1 and IFID_flush = 1 every cycle; other outputs are 0.
  - Exited only by reset.
  - If WB_Halt and a timeout occur in the same cycle, ERROR wins.
- Counters:
  - stall_cnt +1 on every cycle where PC_stall=1 in RUN or MEM_WAIT.
  - flush_cnt +1 on every cycle where IFID_flush=1 in RUN or MEM_WAIT.
  - Both saturate at 2^CNT_W-1 (no wrap).
  - Neither counts in HALTED or ERROR.
- Reset mid-freeze:
  - Outputs drop to 0 immediately (asynchronous); the state returns to RUN.

Decomposition:
- Shared package pipe_pkg holds:
  - the state enum {RUN, MEM_WAIT, HALTED, ERROR};
  - REG_W=4;
  - the ZERO_REG constant.
- One natural sub-module: sat_counter (CNT_W-bit, inc enable, async active-low clear). It is instantiated twice, for stall_cnt and flush_cnt.

Test Plan:
- Load-use bubble: EX_MemRead=1, EX_RegWrite=1, EX_destReg=3; ID_rs=3, ID_rsValid=1 → PC_stall=IFID_stall=IDEX_bubble=1 for 1 cycle; stall_cnt=1. The next cycle, with EX a NOP, all controls are 0.
- Register 0 is immune: same as the load-use scenario but EX_destReg=0 → no stall; stall_cnt stays 0.
- Memory wait: MEM_MemAccess=1, dmem_ready low for 3 cycles then high → freeze plus MEMWB_bubble for 3 cycles, then back to RUN; stall_cnt=3.
- Branch during load-use: ID_BranchTaken=1 together with load_use → IFID_flush=0, IDEX_bubble=1. The next cycle, with the branch still taken → IFID_flush=1; flush_cnt=1.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0 → state ERROR and mem_err=1 after 4 cycles; the freeze persists; rst_n low clears everything to the reset values.
- Halt and saturation:
  - WB_Halt pulse → halted=1 sticky, PC_stall=1 and IFID_flush=1 each cycle.
  - With CNT_W=2, force 5 stalls → stall_cnt saturates at 3.
